// File: rtl/uart_tx_module.sv
// uart_tx_module: 8N1 UART transmitter, LSB first, idle-high line.
// Bit timing comes from an external oversampling tick (OVERSAMPLE ticks per bit).
// All state updates on the falling clock edge; reset is asynchronous active-high.
// Optional macro UART_TX_BUFF_EN adds a one-entry holding register so the next
// byte can be queued during a frame and sent with no idle gap.
module uart_tx_module #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_baud_tick,
    input  logic       tx_start,
    input  logic [7:0] parallel_tx_in,
    output logic       serial_tx,
    output logic       tx_ready,
    output logic       tx_done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t     state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       serial_tx_q, serial_tx_d;
    logic       tx_ready_q, tx_ready_d;
    logic       tx_done_q, tx_done_d;
    logic       accept;
    logic       bit_end;
`ifdef UART_TX_BUFF_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       direct_load;
`endif

    assign accept  = tx_start && tx_ready_q;
    assign bit_end = tx_baud_tick && (tick_cnt_q == TICK_LAST);

    // Next-state, counter, shifter and registered-output computation
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_done_d  = 1'b0;
`ifdef UART_TX_BUFF_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        direct_load  = 1'b0;
`endif

        if (tx_baud_tick && (state_q != IDLE)) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = parallel_tx_in;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                    state_d    = START;
`ifdef UART_TX_BUFF_EN
                    direct_load = 1'b1;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        stop_cnt_d = '0;
                        state_d    = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        state_d   = IDLE;
`ifdef UART_TX_BUFF_EN
                        // Chain straight into the next start bit: pending byte
                        // first, otherwise a request arriving on this very edge.
                        if (hold_valid_q) begin
                            shift_d      = hold_q;
                            hold_valid_d = 1'b0;
                            bit_cnt_d    = '0;
                            stop_cnt_d   = '0;
                            state_d      = START;
                        end else if (accept) begin
                            shift_d     = parallel_tx_in;
                            bit_cnt_d   = '0;
                            stop_cnt_d  = '0;
                            state_d     = START;
                            direct_load = 1'b1;
                        end
`endif
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_BUFF_EN
        if (accept && !direct_load) begin
            hold_d       = parallel_tx_in;
            hold_valid_d = 1'b1;
        end
        tx_ready_d = !hold_valid_d;
`else
        tx_ready_d = (state_d == IDLE);
`endif

        case (state_d)
            START:   serial_tx_d = 1'b0;
            DATA:    serial_tx_d = shift_d[0];
            default: serial_tx_d = 1'b1;
        endcase
    end

    // State register, falling-edge clocked with asynchronous reset
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= '0;
            shift_q     <= '0;
            serial_tx_q <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
`ifdef UART_TX_BUFF_EN
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            serial_tx_q <= serial_tx_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
`ifdef UART_TX_BUFF_EN
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
`endif
        end
    end

    assign serial_tx = serial_tx_q;
    assign tx_ready  = tx_ready_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed self-checking bench for uart_tx_module (OVERSAMPLE=16, STOP_BITS=1).
// Ticks arrive every 4 clocks; the line level is logged just before each tick edge.
module tb_uart_tx_module;

    logic       clk;
    logic       rst;
    logic       tx_baud_tick;
    logic       tx_start;
    logic [7:0] parallel_tx_in;
    logic       serial_tx;
    logic       tx_ready;
    logic       tx_done;

    int checks;
    int errors;
    int tick_num;
    logic line_log[$];
    logic rdy_log[$];
    int   done_at[$];

`ifdef UART_TX_BUFF_EN
    localparam logic BUSY_READY = 1'b1;
`else
    localparam logic BUSY_READY = 1'b0;
`endif

    uart_tx_module #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_baud_tick   (tx_baud_tick),
        .tx_start       (tx_start),
        .parallel_tx_in (parallel_tx_in),
        .serial_tx      (serial_tx),
        .tx_ready       (tx_ready),
        .tx_done        (tx_done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected line level for frame bit idx (0 start, 1..8 data, 9 stop)
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
        logic [7:0] sh;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        sh = b >> (idx - 1);
        return sh[0];
    endfunction

    task automatic clk_cycle(input logic tick);
        tx_baud_tick = tick;
        @(negedge clk);
        #1;
        tx_baud_tick = 1'b0;
        tx_start     = 1'b0;
        if (tx_done === 1'b1) done_at.push_back(tick_num);
    endtask

    task automatic tick_period();
        repeat (3) clk_cycle(1'b0);
        line_log.push_back(serial_tx);
        rdy_log.push_back(tx_ready);
        tick_num++;
        clk_cycle(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        tx_start       = 1'b1;
        parallel_tx_in = b;
        clk_cycle(1'b0);
    endtask

    task automatic clear_logs();
        line_log.delete();
        rdy_log.delete();
        done_at.delete();
        tick_num = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", serial_tx); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        clear_logs();
        repeat (100) tick_period();
        for (int i = 0; i < 100; i++) begin
            checks++; if (line_log[i] !== 1'b1) begin errors++; $display("FAIL idle_line tick %0d: got %b expected 1", i, line_log[i]); end
            checks++; if (rdy_log[i] !== 1'b1) begin errors++; $display("FAIL idle_ready tick %0d: got %b expected 1", i, rdy_log[i]); end
        end
        checks++; if (done_at.size() != 0) begin errors++; $display("FAIL idle_done: got %0d pulses expected 0", done_at.size()); end
    endtask

    task automatic test_frame_a5();
        clear_logs();
        send(8'hA5);
        checks++; if (serial_tx !== 1'b0) begin errors++; $display("FAIL a5_start_edge: got %b expected 0", serial_tx); end
        checks++; if (tx_ready !== BUSY_READY) begin errors++; $display("FAIL a5_ready_accept: got %b expected %b", tx_ready, BUSY_READY); end
        repeat (160) tick_period();
        for (int i = 0; i < 160; i++) begin
            checks++;
            if (line_log[i] !== frame_bit(8'hA5, i / 16)) begin
                errors++; $display("FAIL a5_line tick %0d: got %b expected %b", i, line_log[i], frame_bit(8'hA5, i / 16));
            end
            checks++; if (rdy_log[i] !== BUSY_READY) begin errors++; $display("FAIL a5_ready tick %0d: got %b expected %b", i, rdy_log[i], BUSY_READY); end
        end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_end: got %b expected 1", tx_ready); end
        repeat (4) tick_period();
        checks++; if (done_at.size() != 1) begin errors++; $display("FAIL a5_done_count: got %0d expected 1", done_at.size()); end
        if (done_at.size() >= 1) begin
            checks++; if (done_at[0] != 160) begin errors++; $display("FAIL a5_done_tick: got %0d expected 160", done_at[0]); end
        end
        checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL a5_idle_after: got %b expected 1", serial_tx); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send(8'h00);
        for (int i = 0; i < 200 && done_at.size() == 0; i++) tick_period();
        checks++; if (done_at.size() != 1) begin errors++; $display("FAIL b2b_first_done: got %0d pulses expected 1", done_at.size()); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b expected 1", tx_ready); end
        send(8'hFF);
        checks++; if (serial_tx !== 1'b0) begin errors++; $display("FAIL b2b_second_start: got %b expected 0", serial_tx); end
        while (tick_num < 320) tick_period();
        for (int i = 0; i < 320; i++) begin
            logic e;
            e = (i < 160) ? frame_bit(8'h00, i / 16) : frame_bit(8'hFF, (i - 160) / 16);
            checks++; if (line_log[i] !== e) begin errors++; $display("FAIL b2b_line tick %0d: got %b expected %b", i, line_log[i], e); end
        end
        checks++; if (done_at.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_at.size()); end
        if (done_at.size() == 2) begin
            checks++; if (done_at[1] - done_at[0] != 160) begin errors++; $display("FAIL b2b_done_gap: got %0d expected 160", done_at[1] - done_at[0]); end
        end
    endtask

    task automatic test_mid_frame();
        int exp_done;
        clear_logs();
        send(8'h11);
        repeat (40) tick_period();
        send(8'h3C);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_after_3c: got %b expected 0", tx_ready); end
        repeat (40) tick_period();
        send(8'h77);
        while (tick_num < 340) tick_period();
        for (int i = 0; i < 340; i++) begin
            logic e;
            if (i < 160) e = frame_bit(8'h11, i / 16);
`ifdef UART_TX_BUFF_EN
            else if (i < 320) e = frame_bit(8'h3C, (i - 160) / 16);
`endif
            else e = 1'b1;
            checks++; if (line_log[i] !== e) begin errors++; $display("FAIL mid_line tick %0d: got %b expected %b", i, line_log[i], e); end
        end
`ifdef UART_TX_BUFF_EN
        exp_done = 2;
`else
        exp_done = 1;
`endif
        checks++; if (done_at.size() != exp_done) begin errors++; $display("FAIL mid_done_count: got %0d expected %0d", done_at.size(), exp_done); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_end: got %b expected 1", tx_ready); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send(8'hA5);
        repeat (72) tick_period();
        checks++; if (serial_tx !== 1'b0) begin errors++; $display("FAIL rmid_bit3: got %b expected 0", serial_tx); end
        #2 rst = 1'b1;
        #1;
        checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL rmid_async_line: got %b expected 1", serial_tx); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_async_ready: got %b expected 1", tx_ready); end
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        clear_logs();
        repeat (200) tick_period();
        for (int i = 0; i < 200; i++) begin
            checks++; if (line_log[i] !== 1'b1) begin errors++; $display("FAIL rmid_idle tick %0d: got %b expected 1", i, line_log[i]); end
        end
        checks++; if (done_at.size() != 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", done_at.size()); end
        clear_logs();
        send(8'h81);
        repeat (160) tick_period();
        for (int i = 0; i < 160; i++) begin
            checks++;
            if (line_log[i] !== frame_bit(8'h81, i / 16)) begin
                errors++; $display("FAIL rmid_81_line tick %0d: got %b expected %b", i, line_log[i], frame_bit(8'h81, i / 16));
            end
        end
        checks++; if (done_at.size() != 1) begin errors++; $display("FAIL rmid_81_done: got %0d expected 1", done_at.size()); end
    endtask

    // Decodes the logged line mid-bit, as a receiver sampling at tick 8 of 16 would
    task automatic test_loopback();
        logic [7:0] bytes [5];
        bytes = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h5A};
        clear_logs();
        for (int f = 0; f < 5; f++) begin
            int n;
            n = done_at.size();
            send(bytes[f]);
            for (int i = 0; i < 200 && done_at.size() == n; i++) tick_period();
            checks++; if (done_at.size() != n + 1) begin errors++; $display("FAIL loop_done frame %0d: got %0d expected %0d", f, done_at.size(), n + 1); end
        end
        for (int f = 0; f < 5; f++) begin
            logic [7:0] rx;
            int base;
            base = f * 160;
            rx = '0;
            if (line_log.size() < base + 160) begin
                checks++; errors++; $display("FAIL loop_len frame %0d: got %0d ticks expected %0d", f, line_log.size(), base + 160);
            end else begin
                for (int k = 0; k < 8; k++) rx[k] = line_log[base + 16 * (k + 1) + 8];
                checks++; if (line_log[base + 8] !== 1'b0) begin errors++; $display("FAIL loop_start frame %0d: got %b expected 0", f, line_log[base + 8]); end
                checks++; if (rx !== bytes[f]) begin errors++; $display("FAIL loop_byte frame %0d: got %h expected %h", f, rx, bytes[f]); end
                checks++; if (line_log[base + 152] !== 1'b1) begin errors++; $display("FAIL loop_stop frame %0d: got %b expected 1", f, line_log[base + 152]); end
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        tick_num       = 0;
        rst            = 1'b1;
        tx_baud_tick   = 1'b0;
        tx_start       = 1'b0;
        parallel_tx_in = '0;
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_mid_frame();
        test_reset_mid();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
# uart_tx_module

Serial transmitter for the synchronous UART: accepts an 8-bit parallel byte and shifts it out LSB-first as start bit, 8 data bits and stop bit(s). Bit timing is driven by an external oversampling baud tick (16 ticks per bit), the same tick source the receiver uses. The block sits between the host-side byte source and the `serial_tx` pin. Its frame format matches the receiver: 8N1, LSB first, idle high.

## Interface
- `OVERSAMPLE`, default 16: `tx_baud_tick` pulses per bit period; legal range 2..16; counter is 4 bits.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  single clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `tx_baud_tick`  in  1  one-`clk`-wide oversampling strobe.
- `tx_start`  in  1  request to send `parallel_tx_in`; honoured only while `tx_ready`=1.
- `parallel_tx_in`  in  8  byte to send; sampled on the accepting edge only.
- `serial_tx`  out  1  registered serial line; idle 1.
- `tx_ready`  out  1  byte can be accepted this cycle.
- `tx_done`  out  1  one-`clk` pulse at the end of each frame's last stop bit.

## Operation
- All registers update on the falling edge of `clk`. `rst`=1 forces the following immediately, regardless of clock: state IDLE, `serial_tx`=1, `tx_ready`=1, `tx_done`=0, all counters 0, and the holding register (if built) empty.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `serial_tx`=1.
  - On `tx_start`&`tx_ready`, load the shifter with `parallel_tx_in`, clear `tick_cnt` and `bit_cnt`, and go to START. Acceptance does not wait for a tick.
- START:
  - `serial_tx`=0.
  - Each tick increments `tick_cnt`. On the tick where `tick_cnt`==`OVERSAMPLE`-1, clear `tick_cnt` and go to DATA.
- DATA:
  - `serial_tx`=shifter[0].
  - On the tick ending the bit: shift right, clear `tick_cnt`, increment `bit_cnt`.
  - After bit 7, go to STOP.
- STOP:
  - `serial_tx`=1 for `OVERSAMPLE`*`STOP_BITS` ticks.
  - On the final tick, pulse `tx_done` and go to IDLE, or to START if a byte is pending (see Configuration).
- Ticks arriving in IDLE are ignored.
- Without `tx_baud_tick` the FSM holds its state indefinitely.
- `tx_start` while `tx_ready`=0 is dropped silently.
- `tx_start` held high for several cycles is accepted once per acceptance opportunity, not once per cycle of assertion.

## Timing
- Accept at edge N: `serial_tx` falls after edge N; `tx_ready` is 0 after edge N.
- Start-bit duration: from edge N to the `OVERSAMPLE`th subsequent tick.
- Each data bit and each stop bit lasts exactly `OVERSAMPLE` ticks.
- Frame length for `STOP_BITS`=1: (10 × `OVERSAMPLE`) ticks, measured from the first tick after accept.
- `tx_done`: high for exactly one `clk` cycle, following the edge that sees the final stop tick.
- `tx_ready` (non-buffered build): rises on that same edge.
- A back-to-back `tx_start` in the cycle `tx_ready` rises is accepted. No extra idle bit is inserted beyond the tick alignment.
- Reset asserted mid-frame: the line returns high immediately and the partial frame is abandoned. The first frame after release starts only on a new `tx_start`.

## Configuration
- Macro `UART_TX_BUFF_EN`.
- Defined: adds a one-entry holding register.
  - `tx_ready` = holding register empty.
  - A byte is accepted in any state when the holding register is empty. In IDLE it goes straight to the shifter, as in the non-buffered build.
  - At the STOP-end edge with a pending byte: move it to the shifter, go directly to START (no idle gap), pulse `tx_done`, and set `tx_ready` to 1.
  - Simultaneous `tx_start` at the STOP-end edge with an empty holding register: the byte goes straight to the shifter and START.
- Undefined: no holding register. `tx_ready`=1 only in IDLE.

## Test plan
- Reset release, no start, 100 ticks -> `serial_tx`=1, `tx_ready`=1, `tx_done` never asserted.
- Send 0xA5, tick every 4 clks -> line 0,1,0,1,0,0,1,0,1,1, each level 16 ticks wide; one `tx_done` pulse; `tx_ready` 0 for the whole frame.
- Send 0x00, then 0xFF on the cycle `tx_ready` rises -> two contiguous frames (start, 8×0, stop, start, 8×1, stop); two `tx_done` pulses, 160 ticks apart.
- `tx_start` with 0x3C mid-frame in the non-buffered build -> ignored, only the first byte is sent. In the `UART_TX_BUFF_EN` build, 0x3C follows with no idle gap, and a third `tx_start` during the first frame is dropped.
- `rst` pulsed during data bit 3 -> `serial_tx`=1 asynchronously, with no `tx_done`. A subsequent send of 0x81 produces a clean, full frame.
- Loopback into the team's UART receiver, with `STOP_BITS`=1 and bytes 0x00, 0x55, 0xAA, 0xFF, 0x5A -> the receiver's parallel output matches each byte in order.
